// File: rtl/crosswalk_timer_ctrl.sv
// crosswalk_timer_ctrl
//   Pedestrian crossing controller. Drives a 3-lamp car signal and a 2-lamp
//   pedestrian signal, counts each phase down in whole seconds and shows the
//   remaining time on two multiplexed 2-digit 7-segment displays.
//   Walk requests are latched while cars are being served, and the last
//   PEO_FLASH seconds of the walk phase flash the walk lamp.
//
//   Optional build macro: ZERO_BLANK_EN
//     defined   -> a zero tens digit is blanked (0000000) during a countdown
//     undefined -> a zero tens digit shows a leading zero (1111110)
//   Dash displays are never affected by the macro.
module crosswalk_timer_ctrl #(
    parameter int HALF_SEC_CYC = 5000000,
    parameter int SCAN_CYC     = 5000,
    parameter int CAR_GREEN    = 10,
    parameter int CAR_YELLOW   = 3,
    parameter int ALL_RED      = 1,
    parameter int PEO_GREEN    = 10,
    parameter int PEO_FLASH    = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       str,
    input  logic       inp,
    output logic [2:0] car_o,
    output logic [1:0] peo_o,
    output logic [6:0] FND_car,
    output logic [6:0] FND_peo,
    output logic       FND_carSel1,
    output logic       FND_carSel2,
    output logic       FND_peoSel1,
    output logic       FND_peoSel2
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CAR_GO  = 3'd1;
    localparam logic [2:0] S_CAR_YEL = 3'd2;
    localparam logic [2:0] S_ALL_RED = 3'd3;
    localparam logic [2:0] S_PEO_GO  = 3'd4;

    localparam int HALF_W = (HALF_SEC_CYC > 1) ? $clog2(HALF_SEC_CYC) : 1;
    localparam int SCAN_W = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
    localparam logic [HALF_W-1:0] HALF_LAST = HALF_W'(HALF_SEC_CYC - 1);
    localparam logic [SCAN_W-1:0] SCAN_LAST = SCAN_W'(SCAN_CYC - 1);

    localparam logic [6:0] CAR_GREEN_SEC  = 7'(CAR_GREEN);
    localparam logic [6:0] CAR_YELLOW_SEC = 7'(CAR_YELLOW);
    localparam logic [6:0] ALL_RED_SEC    = 7'(ALL_RED);
    localparam logic [6:0] PEO_GREEN_SEC  = 7'(PEO_GREEN);
    localparam logic [6:0] PEO_FLASH_SEC  = 7'(PEO_FLASH);
    localparam logic [6:0] DASH           = 7'b0000001;

    logic [2:0]        state, state_nxt;
    logic [6:0]        rem, rem_nxt;
    logic              req, req_nxt;
    logic              load;
    logic [HALF_W-1:0] half_cnt, half_cnt_nxt;
    logic              half_ph, half_ph_nxt;
    logic              half_tick, sec_tick;
    logic [SCAN_W-1:0] scan_cnt, scan_cnt_nxt;
    logic              sel_tens, sel_tens_nxt;
    logic [6:0]        fnd_car_nxt, fnd_peo_nxt;
    logic              in_flash;

    // half_ph is low in the first half of each second and high in the second
    assign half_tick = (half_cnt == HALF_LAST);
    assign sec_tick  = half_tick && half_ph;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1111110;
            4'd1:    s = 7'b0110000;
            4'd2:    s = 7'b1101101;
            4'd3:    s = 7'b1111001;
            4'd4:    s = 7'b0110011;
            4'd5:    s = 7'b1011011;
            4'd6:    s = 7'b1011111;
            4'd7:    s = 7'b1110000;
            4'd8:    s = 7'b1111111;
            4'd9:    s = 7'b1111011;
            default: s = DASH;
        endcase
        return s;
    endfunction

    // One display digit: dash when the display is idle, else tens or units of val
    function automatic logic [6:0] fnd_digit(input logic show, input logic [6:0] val,
                                             input logic tens);
        logic [3:0] tens_v;
        logic [3:0] units_v;
        logic [6:0] s;
        tens_v  = 4'(val / 7'd10);
        units_v = 4'(val % 7'd10);
        if (!show) begin
            s = DASH;
        end else if (!tens) begin
            s = seg7(units_v);
        end
`ifdef ZERO_BLANK_EN
        else if (tens_v == 4'd0) begin
            s = 7'b0000000;
        end
`endif
        else begin
            s = seg7(tens_v);
        end
        return s;
    endfunction

    // Phase sequencing, countdown and walk-request latch
    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        req_nxt   = req;
        load      = 1'b0;
        if (sec_tick && (rem != 7'd0)) begin
            rem_nxt = rem - 7'd1;
        end
        if (!inp && ((state == S_CAR_GO) || (state == S_CAR_YEL) || (state == S_ALL_RED))) begin
            req_nxt = 1'b1;
        end
        case (state)
            S_IDLE: begin
                state_nxt = S_CAR_GO;
                rem_nxt   = CAR_GREEN_SEC;
                load      = 1'b1;
            end
            S_CAR_GO: begin
                if ((rem == 7'd0) && req) begin
                    state_nxt = S_CAR_YEL;
                    rem_nxt   = CAR_YELLOW_SEC;
                    load      = 1'b1;
                end
            end
            S_CAR_YEL: begin
                if (rem == 7'd0) begin
                    state_nxt = S_ALL_RED;
                    rem_nxt   = ALL_RED_SEC;
                    load      = 1'b1;
                end
            end
            S_ALL_RED: begin
                if (rem == 7'd0) begin
                    state_nxt = S_PEO_GO;
                    rem_nxt   = PEO_GREEN_SEC;
                    req_nxt   = 1'b0;
                    load      = 1'b1;
                end
            end
            S_PEO_GO: begin
                if (rem == 7'd0) begin
                    state_nxt = S_CAR_GO;
                    rem_nxt   = CAR_GREEN_SEC;
                    load      = 1'b1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                rem_nxt   = 7'd0;
                req_nxt   = 1'b0;
                load      = 1'b1;
            end
        endcase
        // Dropping the run enable parks the controller exactly like reset
        if (!str) begin
            state_nxt = S_IDLE;
            rem_nxt   = 7'd0;
            req_nxt   = 1'b0;
            load      = 1'b1;
        end
    end

    // Half-second divider, restarted on every phase entry
    always_comb begin
        half_cnt_nxt = half_cnt + HALF_W'(1);
        half_ph_nxt  = half_ph;
        if (load) begin
            half_cnt_nxt = '0;
            half_ph_nxt  = 1'b0;
        end else if (half_tick) begin
            half_cnt_nxt = '0;
            half_ph_nxt  = ~half_ph;
        end
    end

    // Digit scan and segment selection for the upcoming cycle
    always_comb begin
        scan_cnt_nxt = scan_cnt + SCAN_W'(1);
        sel_tens_nxt = sel_tens;
        if (scan_cnt == SCAN_LAST) begin
            scan_cnt_nxt = '0;
            sel_tens_nxt = ~sel_tens;
        end
        fnd_car_nxt = fnd_digit((state_nxt == S_CAR_GO) || (state_nxt == S_CAR_YEL),
                                rem_nxt, sel_tens_nxt);
        fnd_peo_nxt = fnd_digit(state_nxt == S_PEO_GO, rem_nxt, sel_tens_nxt);
    end

    // State, counters and display registers
    always_ff @(posedge clk) begin
        if (!rst) begin
            state    <= S_IDLE;
            rem      <= 7'd0;
            req      <= 1'b0;
            half_cnt <= '0;
            half_ph  <= 1'b0;
            scan_cnt <= '0;
            sel_tens <= 1'b0;
            FND_car  <= DASH;
            FND_peo  <= DASH;
        end else begin
            state    <= state_nxt;
            rem      <= rem_nxt;
            req      <= req_nxt;
            half_cnt <= half_cnt_nxt;
            half_ph  <= half_ph_nxt;
            scan_cnt <= scan_cnt_nxt;
            sel_tens <= sel_tens_nxt;
            FND_car  <= fnd_car_nxt;
            FND_peo  <= fnd_peo_nxt;
        end
    end

    // Car and pedestrian displays scan in lockstep
    assign FND_carSel1 = ~sel_tens;
    assign FND_carSel2 = sel_tens;
    assign FND_peoSel1 = ~sel_tens;
    assign FND_peoSel2 = sel_tens;

    // Lamp decode from state; walk lamp blinks with the half-second phase
    always_comb begin
        car_o    = 3'b000;
        peo_o    = 2'b00;
        in_flash = (state == S_PEO_GO) && (rem != 7'd0) && (rem <= PEO_FLASH_SEC);
        case (state)
            S_CAR_GO: begin
                car_o = 3'b100;
                peo_o = 2'b01;
            end
            S_CAR_YEL: begin
                car_o = 3'b010;
                peo_o = 2'b01;
            end
            S_ALL_RED: begin
                car_o = 3'b001;
                peo_o = 2'b01;
            end
            S_PEO_GO: begin
                car_o = 3'b001;
                peo_o = (in_flash && half_ph) ? 2'b00 : 2'b10;
            end
            default: begin
                car_o = 3'b000;
                peo_o = 2'b00;
            end
        endcase
    end

endmodule

// File: tb/tb_crosswalk_timer_ctrl.sv
// Bench for crosswalk_timer_ctrl. Two instances share the board inputs: one
// with a 4 s walk phase and one with a 12 s walk phase (two-digit display).
// The reference model tracks each phase as "cycles since phase entry" and
// derives the remaining seconds and flash phase arithmetically from that.
module tb_crosswalk_timer_ctrl;

    localparam int H    = 4;
    localparam int SCAN = 2;
    localparam int W    = 23;

    localparam int P_IDLE = 0;
    localparam int P_GO   = 1;
    localparam int P_YEL  = 2;
    localparam int P_RED  = 3;
    localparam int P_PEO  = 4;

`ifdef ZERO_BLANK_EN
    localparam logic [6:0] TENS_ZERO = 7'b0000000;
`else
    localparam logic [6:0] TENS_ZERO = 7'b1111110;
`endif

    logic clk = 1'b0;
    logic rst, str, inp;

    logic [2:0] car0, car1;
    logic [1:0] peo0, peo1;
    logic [6:0] fc0, fp0, fc1, fp1;
    logic       cs1_0, cs2_0, ps1_0, ps2_0;
    logic       cs1_1, cs2_1, ps1_1, ps2_1;

    logic [6:0] seg_tab [10] = '{7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001, 7'b0110011,
                                 7'b1011011, 7'b1011111, 7'b1110000, 7'b1111111, 7'b1111011};

    logic [2*W-1:0] exp_q[$];
    int n_checks = 0;
    int n_fail   = 0;

    // model state
    int m_ph [2];
    int m_t  [2];
    bit m_req [2];
    int m_n = 0;
    bit m_last_rst = 1'b0;

    crosswalk_timer_ctrl #(
        .HALF_SEC_CYC(H), .SCAN_CYC(SCAN), .CAR_GREEN(3), .CAR_YELLOW(2),
        .ALL_RED(1), .PEO_GREEN(4), .PEO_FLASH(2)
    ) dut0 (
        .clk(clk), .rst(rst), .str(str), .inp(inp),
        .car_o(car0), .peo_o(peo0), .FND_car(fc0), .FND_peo(fp0),
        .FND_carSel1(cs1_0), .FND_carSel2(cs2_0), .FND_peoSel1(ps1_0), .FND_peoSel2(ps2_0)
    );

    crosswalk_timer_ctrl #(
        .HALF_SEC_CYC(H), .SCAN_CYC(SCAN), .CAR_GREEN(3), .CAR_YELLOW(2),
        .ALL_RED(1), .PEO_GREEN(12), .PEO_FLASH(2)
    ) dut1 (
        .clk(clk), .rst(rst), .str(str), .inp(inp),
        .car_o(car1), .peo_o(peo1), .FND_car(fc1), .FND_peo(fp1),
        .FND_carSel1(cs1_1), .FND_carSel2(cs2_1), .FND_peoSel1(ps1_1), .FND_peoSel2(ps2_1)
    );

    // clock / watchdog
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d",
                 n_checks, n_fail);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual %h required %h (time %0t)", name, act, exp, $time);
        end
    endtask

    task automatic bound_check(input string name, input bit reached);
        n_checks++;
        if (!reached) begin
            n_fail++;
            $display("FAIL %s: actual not-reached required reached", name);
        end
    endtask

    // reference model
    function automatic int dur(input int ph, input int k);
        case (ph)
            P_GO:    return 3;
            P_YEL:   return 2;
            P_RED:   return 1;
            P_PEO:   return (k == 1) ? 12 : 4;
            default: return 0;
        endcase
    endfunction

    function automatic int rem_of(input int k);
        int d;
        d = dur(m_ph[k], k) - m_t[k] / (2 * H);
        return (d < 0) ? 0 : d;
    endfunction

    function automatic logic [6:0] digit(input bit show, input int r, input int sel);
        if (!show) return 7'b0000001;
        if (sel == 0) return seg_tab[r % 10];
        if (r / 10 == 0) return TENS_ZERO;
        return seg_tab[r / 10];
    endfunction

    function automatic logic [W-1:0] model_out(input int k);
        int r;
        int sel;
        logic [2:0] c;
        logic [1:0] p;
        logic [6:0] fc, fp;
        r   = rem_of(k);
        sel = (m_n / SCAN) % 2;
        c   = 3'b000;
        p   = 2'b00;
        case (m_ph[k])
            P_GO:  begin c = 3'b100; p = 2'b01; end
            P_YEL: begin c = 3'b010; p = 2'b01; end
            P_RED: begin c = 3'b001; p = 2'b01; end
            P_PEO: begin
                c = 3'b001;
                p = (r > 0 && r <= 2 && ((m_t[k] / H) % 2 == 1)) ? 2'b00 : 2'b10;
            end
            default: begin c = 3'b000; p = 2'b00; end
        endcase
        fc = digit(m_ph[k] == P_GO || m_ph[k] == P_YEL, r, sel);
        fp = digit(m_ph[k] == P_PEO, r, sel);
        return {c, p, fc, fp, sel == 0, sel == 1, sel == 0, sel == 1};
    endfunction

    task automatic model_step(input logic r, input logic s, input logic i);
        int rr;
        int np;
        m_last_rst = !r;
        if (!r) begin
            m_n = 0;
            for (int k = 0; k < 2; k++) begin
                m_ph[k] = P_IDLE; m_t[k] = 0; m_req[k] = 1'b0;
            end
        end else begin
            m_n++;
            for (int k = 0; k < 2; k++) begin
                if (!s) begin
                    m_ph[k] = P_IDLE; m_t[k] = 0; m_req[k] = 1'b0;
                end else begin
                    rr = rem_of(k);
                    np = m_ph[k];
                    case (m_ph[k])
                        P_IDLE: np = P_GO;
                        P_GO:   if (rr == 0 && m_req[k]) np = P_YEL;
                        P_YEL:  if (rr == 0) np = P_RED;
                        P_RED:  if (rr == 0) np = P_PEO;
                        P_PEO:  if (rr == 0) np = P_GO;
                        default: np = P_IDLE;
                    endcase
                    if (!i && (m_ph[k] == P_GO || m_ph[k] == P_YEL || m_ph[k] == P_RED))
                        m_req[k] = 1'b1;
                    if (np == P_PEO && m_ph[k] != P_PEO) m_req[k] = 1'b0;
                    if (np != m_ph[k]) m_t[k] = 0;
                    else m_t[k]++;
                    m_ph[k] = np;
                end
            end
        end
    endtask

    // checks on outputs with fixed, hand-derived values
    task automatic directed();
        int sel;
        sel = (m_n / SCAN) % 2;
        if (m_last_rst) begin
            check("reset_lamps", W'({car0, peo0}), W'(5'b00000));
            check("reset_fnd", W'({fc0, fp0}), W'({7'b0000001, 7'b0000001}));
            check("reset_sel", W'({cs1_0, cs2_0, ps1_0, ps2_0}), W'(4'b1010));
        end
        if (m_ph[1] == P_PEO && m_t[1] == 0)
            check("peo12_entry", W'(fp1), W'((sel == 1) ? 7'b0110000 : 7'b1101101));
        if (m_ph[1] == P_PEO && rem_of(1) == 7 && sel == 1)
            check("peo12_tens7", W'(fp1), W'(TENS_ZERO));
    endtask

    // driver: apply one cycle of inputs and queue the expected response
    task automatic cyc(input logic r, input logic s, input logic i);
        @(negedge clk);
        directed();
        rst = r;
        str = s;
        inp = i;
        model_step(r, s, i);
        exp_q.push_back({model_out(0), model_out(1)});
    endtask

    // monitor: compare every registered output set against the queue
    initial begin
        logic [2*W-1:0] e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("out_peo4", {car0, peo0, fc0, fp0, cs1_0, cs2_0, ps1_0, ps2_0}, e[2*W-1:W]);
                check("out_peo12", {car1, peo1, fc1, fp1, cs1_1, cs2_1, ps1_1, ps2_1}, e[W-1:0]);
            end
        end
    end

    // stimulus
    initial begin
        logic r, s, i;
        rst = 1'b0;
        str = 1'b1;
        inp = 1'b0;

        // reset with request held
        repeat (3) cyc(1'b0, 1'b1, 1'b0);
        // free run, no requests: green holds at zero
        repeat (200) cyc(1'b1, 1'b1, 1'b1);

        // single press early in green: full cycle back to green
        repeat (2) cyc(1'b0, 1'b1, 1'b1);
        repeat (5) cyc(1'b1, 1'b1, 1'b1);
        cyc(1'b1, 1'b1, 1'b0);
        repeat (150) cyc(1'b1, 1'b1, 1'b1);

        // presses only during walk are ignored
        cyc(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 200 && m_ph[0] != P_PEO; k++) cyc(1'b1, 1'b1, 1'b1);
        bound_check("reach_peo_ignore", m_ph[0] == P_PEO);
        for (int k = 0; k < 100 && m_ph[0] == P_PEO; k++) cyc(1'b1, 1'b1, 1'b0);
        repeat (120) cyc(1'b1, 1'b1, 1'b1);

        // run enable dropped for one cycle mid-walk
        cyc(1'b1, 1'b1, 1'b0);
        for (int k = 0; k < 200 && !(m_ph[0] == P_PEO && m_t[0] == 5); k++)
            cyc(1'b1, 1'b1, 1'b1);
        bound_check("reach_peo_str", m_ph[0] == P_PEO && m_t[0] == 5);
        cyc(1'b1, 1'b0, 1'b1);
        repeat (40) cyc(1'b1, 1'b1, 1'b1);

        // randomized board activity
        repeat (3000) begin
            r = ($urandom_range(0, 499) != 0);
            s = ($urandom_range(0, 199) != 0);
            i = ($urandom_range(0, 29) != 0);
            cyc(r, s, i);
        end
        repeat (4) cyc(1'b1, 1'b1, 1'b1);

        @(posedge clk);
        #2;
        check("queue_drained", W'(exp_q.size()), W'(0));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
